fft2d_seq_ctrl: RTL

Sequencer for the 4x4 2-D FFT. It time-shares one 4-point 1-D FFT core across the row pass and the column pass, using an internal 4x4 complex transpose buffer. It accepts a frame as four row beats, runs row FFTs and then column FFTs through the external core, and drains the result as four row beats. It sits between the frame source and the output sink, in place of the fully parallel 16-input top.

---
 rtl/fft2d_seq_ctrl_pkg.sv | 25 ++
 rtl/fft2d_seq_ctrl_if.sv | 40 ++++
 rtl/fft2d_tbuf.sv | 48 ++++
 rtl/fft2d_seq_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fft2d_seq_ctrl_pkg.sv
// Shared widths, lane indexing and state encoding for the
// time-shared 4x4 2-D FFT sequencer.
package fft2d_seq_ctrl_pkg;

    localparam int DW = 16;
    localparam int EW = 2 * DW;
    localparam int BW = 8 * DW;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROW   = 3'd2,
        COL   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // Lane k of a packed row: {imag, real}, lane 0 in the LSBs.
    function automatic logic [EW-1:0] lane_get(
        input logic [BW-1:0] b,
        input int k
    );
        return b[k*EW +: EW];
    endfunction

endpackage

// File: rtl/fft2d_seq_ctrl_if.sv
// Frame source, FFT core and output sink signals of the
// sequencer, viewed from the controller (slave) or its peers (master).
interface fft2d_seq_ctrl_if;
    import fft2d_seq_ctrl_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          core_in_valid;
    logic [BW-1:0] core_in_data;
    logic          core_out_valid;
    logic [BW-1:0] core_out_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          busy;
    logic          frame_done;
    logic          err;

    modport slave (
        input  in_valid, in_data,
        input  core_out_valid, core_out_data,
        input  out_ready,
        output in_ready,
        output core_in_valid, core_in_data,
        output out_valid, out_data,
        output busy, frame_done, err
    );

    modport master (
        output in_valid, in_data,
        output core_out_valid, core_out_data,
        output out_ready,
        input  in_ready,
        input  core_in_valid, core_in_data,
        input  out_valid, out_data,
        input  busy, frame_done, err
    );

endinterface

// File: rtl/fft2d_tbuf.sv
// 4x4 complex transpose buffer: one row/column write port and one
// write-through row/column read port.
module fft2d_tbuf
    import fft2d_seq_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_col,
    input  logic [1:0]    wr_idx,
    input  logic [BW-1:0] wr_data,
    input  logic          rd_col,
    input  logic [1:0]    rd_idx,
    output logic [BW-1:0] rd_data
);

    logic [EW-1:0] mem   [4][4];
    logic [EW-1:0] mem_n [4][4];

    always_comb begin
        mem_n = mem;
        if (wr_en) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (wr_col ? (c[1:0] == wr_idx)
                               : (r[1:0] == wr_idx)) begin
                        mem_n[r][c] = lane_get(wr_data,
                                               wr_col ? r : c);
                    end
                end
            end
        end
    end

    // Reads see this cycle's write so a phase can start on the
    // same edge that lands the previous phase's last result.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < 4; k++) begin
            rd_data[k*EW +: EW] = rd_col ? mem_n[k][rd_idx]
                                         : mem_n[rd_idx][k];
        end
    end

    always_ff @(posedge clk) begin
        mem <= mem_n;
    end

endmodule

// File: rtl/fft2d_seq_ctrl.sv
// Frame sequencer: load 4 rows, row pass and column pass through a
// shared 4-point core, then drain 4 rows.
module fft2d_seq_ctrl
    import fft2d_seq_ctrl_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    fft2d_seq_ctrl_if.slave io
);

    state_t        state, state_n;
    logic [1:0]    rcnt, rcnt_n;
    logic [1:0]    ocnt, ocnt_n;
    logic [2:0]    icnt, icnt_n;
    logic [2:0]    jcnt, jcnt_n;
    logic [2:0]    outst, outst_n;
    logic          civ_n, ov_n, fd_n, ld_out;
    logic          acc, res;
    logic          wr_en, wr_col, rd_col;
    logic [1:0]    wr_idx, rd_idx;
    logic [BW-1:0] wr_data, rd_data;

    assign io.in_ready = (state == IDLE) || (state == LOAD);
    assign io.busy     = (state != IDLE);
    assign acc         = io.in_valid && io.in_ready;
    assign res         = io.core_out_valid && (outst != 3'd0);
    assign outst_n     = outst + {2'b0, io.core_in_valid}
                               - {2'b0, res};

    fft2d_tbuf u_tbuf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_col  (wr_col),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_col  (rd_col),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_n = state;
        rcnt_n  = rcnt;
        ocnt_n  = ocnt;
        icnt_n  = icnt;
        jcnt_n  = jcnt;
        civ_n   = 1'b0;
        ov_n    = 1'b0;
        fd_n    = 1'b0;
        ld_out  = 1'b0;
        wr_en   = 1'b0;
        wr_col  = 1'b0;
        wr_idx  = jcnt[1:0];
        wr_data = io.core_out_data;
        rd_col  = 1'b0;
        rd_idx  = icnt[1:0];
        unique case (state)
            IDLE: begin
                if (acc) begin
                    wr_en   = 1'b1;
                    wr_idx  = 2'd0;
                    wr_data = io.in_data;
                    rcnt_n  = 2'd1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (acc) begin
                    wr_en   = 1'b1;
                    wr_idx  = rcnt;
                    wr_data = io.in_data;
                    rcnt_n  = rcnt + 2'd1;
                    if (rcnt == 2'd3) begin
                        state_n = ROW;
                        civ_n   = 1'b1;
                        rd_idx  = 2'd0;
                        icnt_n  = 3'd1;
                        jcnt_n  = 3'd0;
                    end
                end
            end
            ROW, COL: begin
                rd_col = (state == COL);
                if (icnt != 3'd4) begin
                    civ_n  = 1'b1;
                    icnt_n = icnt + 3'd1;
                end
                if (res) begin
                    wr_en  = 1'b1;
                    wr_col = (state == COL);
                    jcnt_n = jcnt + 3'd1;
                    if (jcnt == 3'd3) begin
                        jcnt_n = 3'd0;
                        rd_idx = 2'd0;
                        if (state == ROW) begin
                            state_n = COL;
                            civ_n   = 1'b1;
                            rd_col  = 1'b1;
                            icnt_n  = 3'd1;
                        end else begin
                            state_n = DRAIN;
                            ov_n    = 1'b1;
                            ld_out  = 1'b1;
                            rd_col  = 1'b0;
                            ocnt_n  = 2'd0;
                        end
                    end
                end
            end
            DRAIN: begin
                ov_n = 1'b1;
                if (io.out_ready) begin
                    ocnt_n = ocnt + 2'd1;
                    rd_idx = ocnt + 2'd1;
                    ld_out = 1'b1;
                    if (ocnt == 2'd3) begin
                        state_n = IDLE;
                        ov_n    = 1'b0;
                        ld_out  = 1'b0;
                        fd_n    = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            rcnt             <= '0;
            ocnt             <= '0;
            icnt             <= '0;
            jcnt             <= '0;
            outst            <= '0;
            io.err           <= 1'b0;
            io.core_in_valid <= 1'b0;
            io.core_in_data  <= '0;
            io.out_valid     <= 1'b0;
            io.out_data      <= '0;
            io.frame_done    <= 1'b0;
        end else begin
            state            <= state_n;
            rcnt             <= rcnt_n;
            ocnt             <= ocnt_n;
            icnt             <= icnt_n;
            jcnt             <= jcnt_n;
            outst            <= outst_n;
            io.err           <= io.err ||
                                (io.core_out_valid && outst == 3'd0);
            io.core_in_valid <= civ_n;
            io.out_valid     <= ov_n;
            io.frame_done    <= fd_n;
            if (civ_n) io.core_in_data <= rd_data;
            if (ld_out) io.out_data <= rd_data;
        end
    end

endmodule
